// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the shared split-handshake memory bus: D-port has priority,
// fetch is guaranteed a grant after DSTREAK_MAX consecutive D grants while it waits.
module mem_bus_arbiter #(
  parameter int unsigned DSTREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  input  logic [2:0]  ireq_size,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [63:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        breq_valid,
  output logic [63:0] breq_addr,
  output logic [2:0]  breq_size,
  output logic [7:0]  breq_strobe,
  output logic [63:0] breq_data,
  input  logic        bresp_addr_ok,
  input  logic        bresp_data_ok,
  input  logic [63:0] bresp_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(DSTREAK_MAX);

  state_t      state, state_nxt;
  logic        grant;            // 0 = I-port, 1 = D-port
  logic [63:0] lat_addr, lat_data;
  logic [2:0]  lat_size;
  logic [7:0]  lat_strobe;
  logic [3:0]  dstreak;
  logic        start, pick_i;
  logic        bus_addr_ok, bus_data_ok;

  assign start  = (state == IDLE) && (ireq_valid || dreq_valid);
  assign pick_i = ireq_valid && (!dreq_valid || dstreak == STREAK_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant      <= 1'b0;
      lat_addr   <= '0;
      lat_size   <= '0;
      lat_strobe <= '0;
      lat_data   <= '0;
      dstreak    <= '0;
    end else if (start) begin
      if (pick_i) begin
        grant      <= 1'b0;
        lat_addr   <= ireq_addr;
        lat_size   <= ireq_size;
        lat_strobe <= '0;
        lat_data   <= '0;
        dstreak    <= '0;
      end else begin
        grant      <= 1'b1;
        lat_addr   <= dreq_addr;
        lat_size   <= dreq_size;
        lat_strobe <= dreq_strobe;
        lat_data   <= dreq_data;
        // Streak only grows while fetch is actually being held off.
        if (!ireq_valid)                 dstreak <= '0;
        else if (dstreak != STREAK_MAX)  dstreak <= dstreak + 4'd1;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ireq_valid || dreq_valid) state_nxt = REQ;
      REQ:  if (bresp_addr_ok)            state_nxt = bresp_data_ok ? IDLE : WAIT;
      WAIT: if (bresp_data_ok)            state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    breq_valid    = (state == REQ);
    breq_addr     = lat_addr;
    breq_size     = lat_size;
    breq_strobe   = lat_strobe;
    breq_data     = lat_data;
    bus_addr_ok   = (state == REQ) && bresp_addr_ok;
    bus_data_ok   = ((state == REQ) && bresp_addr_ok && bresp_data_ok) ||
                    ((state == WAIT) && bresp_data_ok);
    iresp_addr_ok = bus_addr_ok && !grant;
    iresp_data_ok = bus_data_ok && !grant;
    dresp_addr_ok = bus_addr_ok && grant;
    dresp_data_ok = bus_data_ok && grant;
    iresp_data    = bresp_data;
    dresp_data    = bresp_data;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Cycle-table bench for mem_bus_arbiter: each vector drives one cycle and pushes its
// expected outputs to a scoreboard that is checked on the following falling edge.
module tb_mem_bus_arbiter;

  localparam logic [63:0] I_ADDR = 64'h0000_0000_8000_0000;
  localparam logic [2:0]  I_SIZE = 3'd3;
  localparam logic [63:0] D_ADDR = 64'h0000_0000_8000_1000;
  localparam logic [2:0]  D_SIZE = 3'd2;
  localparam logic [7:0]  D_STRB = 8'h0F;
  localparam logic [63:0] D_DATA = 64'h0000_0000_1122_3344;

  localparam logic [1:0] W_NONE = 2'd0, W_I = 2'd1, W_D = 2'd2, W_ZERO = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid, dreq_valid;
  logic [63:0] ireq_addr, dreq_addr, dreq_data;
  logic [2:0]  ireq_size, dreq_size;
  logic [7:0]  dreq_strobe;
  logic        iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok;
  logic [63:0] iresp_data, dresp_data;
  logic        breq_valid;
  logic [63:0] breq_addr, breq_data;
  logic [2:0]  breq_size;
  logic [7:0]  breq_strobe;
  logic        bresp_addr_ok, bresp_data_ok;
  logic [63:0] bresp_data;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DSTREAK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_size(ireq_size),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .breq_valid(breq_valid), .breq_addr(breq_addr), .breq_size(breq_size),
    .breq_strobe(breq_strobe), .breq_data(breq_data),
    .bresp_addr_ok(bresp_addr_ok), .bresp_data_ok(bresp_data_ok), .bresp_data(bresp_data)
  );

  typedef struct {
    logic        rn, iv, dv, aok, dok;
    logic [63:0] bdata;
    logic        ebv;
    logic [1:0]  who;
    logic        eia, eid, eda, edd;
  } vec_t;

  typedef struct {
    int          idx;
    logic        ebv;
    logic [1:0]  who;
    logic        eia, eid, eda, edd;
    logic [63:0] bdata;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input int idx, input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic rn, input logic iv, input logic dv, input logic aok,
                     input logic dok, input logic [63:0] bd, input logic ebv,
                     input logic [1:0] who, input logic eia, input logic eid,
                     input logic eda, input logic edd);
    vec_t v;
    v.rn = rn; v.iv = iv; v.dv = dv; v.aok = aok; v.dok = dok;
    v.bdata = (bd != 64'd0) ? bd : {32'hC0DE_0000, 32'(vecs.size())};
    v.ebv = ebv; v.who = who; v.eia = eia; v.eid = eid; v.eda = eda; v.edd = edd;
    vecs.push_back(v);
  endtask

  // Scoreboard consumer: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      check(e.idx, "breq_valid",    64'(breq_valid),    64'(e.ebv));
      check(e.idx, "iresp_addr_ok", 64'(iresp_addr_ok), 64'(e.eia));
      check(e.idx, "iresp_data_ok", 64'(iresp_data_ok), 64'(e.eid));
      check(e.idx, "dresp_addr_ok", 64'(dresp_addr_ok), 64'(e.eda));
      check(e.idx, "dresp_data_ok", 64'(dresp_data_ok), 64'(e.edd));
      check(e.idx, "iresp_data",    iresp_data,         e.bdata);
      check(e.idx, "dresp_data",    dresp_data,         e.bdata);
      case (e.who)
        W_I: begin
          check(e.idx, "breq_addr",   breq_addr,          I_ADDR);
          check(e.idx, "breq_size",   64'(breq_size),     64'(I_SIZE));
          check(e.idx, "breq_strobe", 64'(breq_strobe),   64'd0);
          check(e.idx, "breq_data",   breq_data,          64'd0);
        end
        W_D: begin
          check(e.idx, "breq_addr",   breq_addr,          D_ADDR);
          check(e.idx, "breq_size",   64'(breq_size),     64'(D_SIZE));
          check(e.idx, "breq_strobe", 64'(breq_strobe),   64'(D_STRB));
          check(e.idx, "breq_data",   breq_data,          D_DATA);
        end
        W_ZERO: begin
          check(e.idx, "breq_addr",   breq_addr,          64'd0);
          check(e.idx, "breq_size",   64'(breq_size),     64'd0);
          check(e.idx, "breq_strobe", 64'(breq_strobe),   64'd0);
          check(e.idx, "breq_data",   breq_data,          64'd0);
        end
        default: ;
      endcase
    end
  end

  initial begin
    logic [1:0] who;
    exp_t       e;

    reset = 1'b0;
    ireq_valid = 1'b0; ireq_addr = I_ADDR; ireq_size = I_SIZE;
    dreq_valid = 1'b0; dreq_addr = D_ADDR; dreq_size = D_SIZE;
    dreq_strobe = D_STRB; dreq_data = D_DATA;
    bresp_addr_ok = 1'b0; bresp_data_ok = 1'b0; bresp_data = 64'd0;

    // Reset state: every output zero, response data passes straight through.
    add(0,0,0,0,0, 0, 0,W_ZERO, 0,0,0,0);
    add(0,0,0,1,1, 0, 0,W_ZERO, 0,0,0,0);

    // Single D store, bus completes both phases at cycle 3.
    add(1,0,1,0,0, 0, 0,W_NONE, 0,0,0,0);
    add(1,0,1,0,0, 0, 1,W_D,    0,0,0,0);
    add(1,0,1,0,0, 0, 1,W_D,    0,0,0,0);
    add(1,0,1,1,1, 0, 1,W_D,    0,0,1,1);
    add(1,0,0,0,0, 0, 0,W_NONE, 0,0,0,0);

    // Single I fetch, split handshake: addr_ok at cycle 2, data_ok at cycle 5.
    add(1,1,0,0,0, 0,     0,W_NONE, 0,0,0,0);
    add(1,1,0,0,0, 0,     1,W_I,    0,0,0,0);
    add(1,1,0,1,0, 0,     1,W_I,    1,0,0,0);
    add(1,1,0,0,0, 0,     0,W_NONE, 0,0,0,0);
    add(1,1,0,0,0, 0,     0,W_NONE, 0,0,0,0);
    add(1,1,0,0,1, 64'h13,0,W_NONE, 0,1,0,0);
    add(1,0,0,0,0, 0,     0,W_NONE, 0,0,0,0);

    // Stray bus responses in IDLE are ignored.
    add(1,0,0,1,1, 0, 0,W_NONE, 0,0,0,0);
    add(1,0,0,1,1, 0, 0,W_NONE, 0,0,0,0);
    add(1,0,0,0,1, 0, 0,W_NONE, 0,0,0,0);

    // data_ok without addr_ok in REQ is ignored; completion then comes from WAIT.
    add(1,0,1,0,0, 0, 0,W_NONE, 0,0,0,0);
    add(1,0,1,0,1, 0, 1,W_D,    0,0,0,0);
    add(1,0,1,1,0, 0, 1,W_D,    0,0,1,0);
    add(1,0,1,0,0, 0, 0,W_NONE, 0,0,0,0);
    add(1,0,1,0,1, 0, 0,W_NONE, 0,0,0,1);
    add(1,0,0,0,0, 0, 0,W_NONE, 0,0,0,0);

    // Bus stall: addr_ok held low for 10 cycles, request must stay stable.
    add(1,0,1,0,0, 0, 0,W_NONE, 0,0,0,0);
    for (int k = 0; k < 10; k++) add(1,0,1,0,0, 0, 1,W_D, 0,0,0,0);
    add(1,0,1,1,1, 0, 1,W_D,    0,0,1,1);
    add(1,0,0,0,0, 0, 0,W_NONE, 0,0,0,0);

    // Both ports always valid, single-cycle bus: D,D,D,D,I,D,D,D,D,I every 2 cycles.
    for (int k = 0; k < 10; k++) begin
      add(1,1,1,1,1, 0, 0,W_NONE, 0,0,0,0);
      who = (k == 4 || k == 9) ? W_I : W_D;
      add(1,1,1,1,1, 0, 1,who, who == W_I, who == W_I, who == W_D, who == W_D);
    end
    add(1,0,0,0,0, 0, 0,W_NONE, 0,0,0,0);

    // Granted fetch drops valid mid-transaction; transaction still completes to it.
    add(1,1,0,0,0, 0,     0,W_NONE, 0,0,0,0);
    add(1,0,0,0,0, 0,     1,W_I,    0,0,0,0);
    add(1,0,0,1,0, 0,     1,W_I,    1,0,0,0);
    add(1,0,0,0,1, 64'h55,0,W_NONE, 0,1,0,0);
    add(1,0,0,0,0, 0,     0,W_NONE, 0,0,0,0);

    // Reset while in WAIT: outputs clear at once, old data_ok never delivered.
    add(1,0,1,0,0, 0, 0,W_NONE, 0,0,0,0);
    add(1,0,1,0,0, 0, 1,W_D,    0,0,0,0);
    add(1,0,1,1,0, 0, 1,W_D,    0,0,1,0);
    add(1,0,1,0,0, 0, 0,W_NONE, 0,0,0,0);
    add(0,0,1,0,1, 0, 0,W_ZERO, 0,0,0,0);
    add(1,0,0,0,1, 0, 0,W_ZERO, 0,0,0,0);
    add(1,0,1,0,0, 0, 0,W_ZERO, 0,0,0,0);
    add(1,0,1,0,0, 0, 1,W_D,    0,0,0,0);
    add(1,0,1,1,1, 0, 1,W_D,    0,0,1,1);
    add(1,0,0,0,0, 0, 0,W_NONE, 0,0,0,0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset         = vecs[i].rn;
      ireq_valid    = vecs[i].iv;
      dreq_valid    = vecs[i].dv;
      bresp_addr_ok = vecs[i].aok;
      bresp_data_ok = vecs[i].dok;
      bresp_data    = vecs[i].bdata;
      e.idx = i; e.ebv = vecs[i].ebv; e.who = vecs[i].who;
      e.eia = vecs[i].eia; e.eid = vecs[i].eid; e.eda = vecs[i].eda; e.edd = vecs[i].edd;
      e.bdata = vecs[i].bdata;
      sb.push_back(e);
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter and sequencer for the single shared memory bus. Instruction fetch (I-port) and the memory stage (D-port, already formatted by the memory helper into aligned address, size, strobe and lane-shifted data) compete for one downstream split-handshake bus with separate addr_ok and data_ok. The block grants one requester at a time and registers that requester's request onto the bus. It routes the handshake responses back to the winner and keeps one transaction outstanding at most. D-port has priority, with a bounded-streak rule so fetch cannot starve.

## Interface
- DSTREAK_MAX, 4: maximum consecutive D grants while I-port is waiting; range 1..15.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ireq_valid  in  1  fetch request; held until iresp_data_ok.
- ireq_addr  in  64  fetch address.
- ireq_size  in  3  msize_t.
- iresp_addr_ok  out  1  fetch address accepted by bus.
- iresp_data_ok  out  1  fetch data valid.
- iresp_data  out  64  fetch read data.
- dreq_valid  in  1  data request; held until dresp_data_ok.
- dreq_addr  in  64  word-aligned data address.
- dreq_size  in  3  msize_t.
- dreq_strobe  in  8  byte strobe; 0 = load.
- dreq_data  in  64  lane-shifted store data.
- dresp_addr_ok  out  1  data address accepted.
- dresp_data_ok  out  1  data transaction complete.
- dresp_data  out  64  load data.
- breq_valid  out  1  bus request.
- breq_addr  out  64  bus address.
- breq_size  out  3  bus size.
- breq_strobe  out  8  bus strobe.
- breq_data  out  64  bus write data.
- bresp_addr_ok  in  1  bus accepted address.
- bresp_data_ok  in  1  bus data / write complete.
- bresp_data  in  64  bus read data.

## Operation
- States: IDLE, REQ, WAIT. Registers: grant (0 = I, 1 = D), latched request (addr, size, strobe, data), dstreak counter (4 bits).
- IDLE → REQ when either valid is high. Pick D unless ireq_valid && dstreak == DSTREAK_MAX, in which case pick I.
  - On grant, latch the winner's fields. I grants latch strobe = 0 and data = 0.
- D grant while ireq_valid is high: dstreak increments, saturating at DSTREAK_MAX.
- Any I grant clears dstreak. A D grant while ireq_valid is low also clears dstreak.
- REQ: breq_valid = 1 and breq_* = latched fields.
  - bresp_addr_ok routes to the granted port's addr_ok in the same cycle.
  - bresp_addr_ok && !bresp_data_ok → WAIT.
  - bresp_addr_ok && bresp_data_ok → IDLE.
- WAIT: breq_valid = 0. bresp_data_ok routes to the granted port's data_ok, then → IDLE.
- Response data: bresp_data passes combinationally to both iresp_data and dresp_data. Only the granted port sees data_ok.
- The non-granted port's addr_ok and data_ok stay 0 at all times.
- In IDLE, bresp_addr_ok and bresp_data_ok are ignored. No output responds and the state does not change.
- bresp_data_ok in REQ without bresp_addr_ok is ignored.
- If the granted requester drops valid mid-transaction, the latched request is still completed on the bus and data_ok is still routed to it.

## Timing
- Reset (asynchronous, immediate): state IDLE, grant 0, dstreak 0, latched fields 0.
  - All outputs 0: breq_valid, breq_*, iresp_*_ok, dresp_*_ok.
  - iresp_data and dresp_data follow bresp_data combinationally.
- Reset mid-transaction abandons the outstanding bus transaction. No data_ok is delivered.
- Grant latency: request seen in IDLE at cycle t → breq_valid at t+1.
- addr_ok and data_ok responses are combinational, zero-cycle pass-through in the active state.
- Back-to-back: data_ok at cycle m → IDLE at m+1 → next breq_valid at m+2 at the earliest.
  - A requester may present a new request at m+1.
- Bus stall: REQ holds breq_valid and fields stable for any number of cycles until bresp_addr_ok.
- Simultaneous I and D valid in IDLE: D wins unless dstreak == DSTREAK_MAX.
- dstreak never exceeds DSTREAK_MAX.

## Test plan
- Single D store: dreq addr 0x80001000, strobe 0x0F, data 0x11223344, bus addr_ok and data_ok both at cycle 3.
  - Expect breq_valid at cycle 1 with identical fields, dresp_addr_ok and dresp_data_ok at cycle 3, iresp_* = 0.
- Single I fetch with a split handshake: addr_ok at cycle 2, data_ok at cycle 5 with bresp_data 0x00000013.
  - Expect breq_valid only in cycles 1–2 and breq_strobe = 0.
  - Expect iresp_data_ok at cycle 5 with data 0x13.
- Both ports continuously valid, bus single-cycle, DSTREAK_MAX = 4.
  - Expect grant order D,D,D,D,I,D,D,D,D,I with a new breq every 2 cycles.
- Assert reset in WAIT, then release and present a new D request.
  - Expect outputs 0 immediately and dresp_data_ok never for the old transaction.
  - Expect the new D request on the bus 1 cycle after it is presented.
- Spurious bresp_data_ok in IDLE with stray bresp_addr_ok: expect no *_ok output and the state stays IDLE.
- Bus holds addr_ok low for 10 cycles in REQ: expect breq_* stable every cycle.
